// File: rtl/xc_aesmix.sv
// AES MixColumns / InvMixColumns unit: one output byte per cycle over four cycles.
// Define XC_AESMIX_FAST_EN for the single-cycle variant with four parallel byte datapaths.
module xc_aesmix (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // One output byte; x0 is a_i and x1..x3 are a_{i+1}..a_{i+3}.
    function automatic logic [7:0] mix_byte(
        input logic [7:0] x0,
        input logic [7:0] x1,
        input logic [7:0] x2,
        input logic [7:0] x3,
        input logic       fwd
    );
        logic [7:0] x0_2, x0_4, x0_8;
        logic [7:0] x1_2, x1_4, x1_8;
        logic [7:0] x2_2, x2_4, x2_8;
        logic [7:0] x3_2, x3_4, x3_8;
        x0_2 = xt(x0);
        x0_4 = xt(x0_2);
        x0_8 = xt(x0_4);
        x1_2 = xt(x1);
        x1_4 = xt(x1_2);
        x1_8 = xt(x1_4);
        x2_2 = xt(x2);
        x2_4 = xt(x2_2);
        x2_8 = xt(x2_4);
        x3_2 = xt(x3);
        x3_4 = xt(x3_2);
        x3_8 = xt(x3_4);
        if (fwd) begin
            return x0_2 ^ (x1_2 ^ x1) ^ x2 ^ x3;
        end
        // 0E, 0B, 0D, 09 built from the doubling chain
        return (x0_8 ^ x0_4 ^ x0_2) ^
               (x1_8 ^ x1_2 ^ x1)   ^
               (x2_8 ^ x2_4 ^ x2)   ^
               (x3_8 ^ x3);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = rs1[7:0];
    assign a1 = rs1[15:8];
    assign a2 = rs2[23:16];
    assign a3 = rs2[31:24];

`ifdef XC_AESMIX_FAST_EN

    logic [7:0] o0, o1, o2, o3;
    logic       unused_ok;

    assign o0 = mix_byte(a0, a1, a2, a3, enc);
    assign o1 = mix_byte(a1, a2, a3, a0, enc);
    assign o2 = mix_byte(a2, a3, a0, a1, enc);
    assign o3 = mix_byte(a3, a0, a1, a2, enc);

    assign ready  = valid;
    assign result = valid ? {o3, o2, o1, o0} : '0;

    assign unused_ok = ^{clock, reset, flush, flush_data, rs1[31:16], rs2[15:0]};

`else

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [1:0] fsm_q, fsm_d;
    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;
    logic [7:0] b2_q, b2_d;
    logic [7:0] op0, op1, op2, op3;
    logic [7:0] o_byte;
    logic       unused_ok;

    // Rotate the column so the shared datapath always computes output byte fsm_q.
    always_comb begin
        op0 = a0;
        op1 = a1;
        op2 = a2;
        op3 = a3;
        case (fsm_q)
            S1: begin
                op0 = a1;
                op1 = a2;
                op2 = a3;
                op3 = a0;
            end
            S2: begin
                op0 = a2;
                op1 = a3;
                op2 = a0;
                op3 = a1;
            end
            S3: begin
                op0 = a3;
                op1 = a0;
                op2 = a1;
                op3 = a2;
            end
            default: ;
        endcase
    end

    assign o_byte = mix_byte(op0, op1, op2, op3, enc);

    assign ready  = valid & (fsm_q == S3);
    assign result = ready ? {o_byte, b2_q, b1_q, b0_q} : '0;

    always_comb begin
        fsm_d = fsm_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        b2_d  = b2_q;
        if (flush) begin
            fsm_d = S0;
            b0_d  = flush_data[7:0];
            b1_d  = flush_data[15:8];
            b2_d  = flush_data[23:16];
        end else if (valid) begin
            case (fsm_q)
                S0: begin
                    b0_d  = o_byte;
                    fsm_d = S1;
                end
                S1: begin
                    b1_d  = o_byte;
                    fsm_d = S2;
                end
                S2: begin
                    b2_d  = o_byte;
                    fsm_d = S3;
                end
                default: fsm_d = S0;
            endcase
        end else begin
            // A gap in valid aborts the op; stale bytes are overwritten by the next one.
            fsm_d = S0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q <= S0;
            b0_q  <= '0;
            b1_q  <= '0;
            b2_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            b2_q  <= b2_d;
        end
    end

    assign unused_ok = ^{flush_data[31:24], rs1[31:16], rs2[15:0]};

`endif

endmodule

// File: tb/tb_xc_aesmix.sv
// Scoreboard bench for xc_aesmix: directed AES vectors plus randomized stimulus.
// Expectations come from a generic GF(2^8) matrix model and a phase-count protocol model.
module tb_xc_aesmix;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] result;

    xc_aesmix dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_data (flush_data),
        .valid      (valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .enc        (enc),
        .ready      (ready),
        .result     (result)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] res;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    int         phase = 0;
    logic [7:0] mb[3];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int unsigned p, x, y;
        p = 0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y % 2 == 1) p = p ^ x;
            x = x * 2;
            if (x >= 256) x = (x - 256) ^ 8'h1B;
            y = y / 2;
        end
        return p[7:0];
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] r1, input logic [31:0] r2, input bit e);
        logic [7:0]  a[4];
        logic [7:0]  m[4];
        logic [7:0]  o;
        logic [31:0] out;
        a[0] = r1[7:0];
        a[1] = r1[15:8];
        a[2] = r2[23:16];
        a[3] = r2[31:24];
        if (e) begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end else begin
            m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09;
        end
        out = '0;
        for (int i = 0; i < 4; i++) begin
            o = 8'h00;
            for (int j = 0; j < 4; j++) o = o ^ gmul(m[j], a[(i + j) % 4]);
            out[8*i +: 8] = o;
        end
        return out;
    endfunction

    task automatic step(input bit v, input bit e, input logic [31:0] r1, input logic [31:0] r2,
                        input bit fl, input logic [31:0] fd, input bit rst,
                        input bit use_want, input logic [31:0] want);
        logic [31:0] full;
        logic [31:0] exp_res;
        valid      = v;
        enc        = e;
        rs1        = r1;
        rs2        = r2;
        flush      = fl;
        flush_data = fd;
        reset      = rst;
        mon_en     = 1'b1;
        full       = mixcol(r1, r2, e);
`ifdef XC_AESMIX_FAST_EN
        if (v) begin
            exp_res = use_want ? want : full;
            sbq.push_back('{cyc, exp_res});
        end
`else
        if (v && phase == 3) begin
            exp_res = use_want ? want : {full[31:24], mb[2], mb[1], mb[0]};
            sbq.push_back('{cyc, exp_res});
        end
        if (rst) begin
            phase = 0;
            for (int k = 0; k < 3; k++) mb[k] = 8'h00;
        end else if (fl) begin
            phase = 0;
            for (int k = 0; k < 3; k++) mb[k] = fd[8*k +: 8];
        end else if (v) begin
            if (phase < 3) mb[phase] = full[8*phase +: 8];
            phase = (phase + 1) % 4;
        end else begin
            phase = 0;
        end
`endif
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic vcyc(input bit e, input logic [31:0] r1, input logic [31:0] r2);
        step(1'b1, e, r1, r2, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic op(input bit e, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] want);
        for (int i = 0; i < 4; i++) step(1'b1, e, r1, r2, 1'b0, '0, 1'b0, 1'b1, want);
    endtask

    always @(negedge clock) begin
        bit   er;
        exp_t x;
        if (mon_en) begin
            er = (sbq.size() != 0) && (sbq[0].cyc == cyc);
            tests++;
            if (ready !== er) begin
                fails++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, er);
            end
            if (er) begin
                x = sbq.pop_front();
                tests++;
                if (result !== x.res) begin
                    fails++;
                    $display("FAIL result cyc=%0d got=%08h exp=%08h", cyc, result, x.res);
                end
            end else if (ready === 1'b0) begin
                tests++;
                if (result !== 32'h0) begin
                    fails++;
                    $display("FAIL gating cyc=%0d got=%08h exp=00000000", cyc, result);
                end
            end
        end
    end

    initial begin
        logic [31:0] r1, r2;
        bit          e;
        int unsigned rnd;
        reset      = 1'b1;
        flush      = 1'b0;
        flush_data = '0;
        valid      = 1'b0;
        rs1        = '0;
        rs2        = '0;
        enc        = 1'b0;
        for (int k = 0; k < 3; k++) mb[k] = 8'h00;
        @(posedge clock);
        #1;
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        idle(2);

        op(1'b1, 32'h000013DB, 32'h45530000, 32'hBCA14D8E);
        idle(1);
        op(1'b0, 32'h00004D8E, 32'hBCA10000, 32'h455313DB);
        idle(1);
        op(1'b1, 32'h00000AF2, 32'h5C220000, 32'h9D58DC9F);
        op(1'b1, 32'h0000C6C6, 32'hC6C60000, 32'hC6C6C6C6);
        idle(1);

        // Abort: two valid cycles, one gap, then a full op.
        vcyc(1'b1, 32'h000013DB, 32'h45530000);
        vcyc(1'b1, 32'h000013DB, 32'h45530000);
        idle(1);
        op(1'b0, 32'h00004D8E, 32'hBCA10000, 32'h455313DB);
        idle(1);

        // Flush in S2 with valid still high.
        vcyc(1'b1, 32'h00000AF2, 32'h5C220000);
        vcyc(1'b1, 32'h00000AF2, 32'h5C220000);
        step(1'b1, 1'b1, 32'h00000AF2, 32'h5C220000, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, '0);
        op(1'b1, 32'h00000AF2, 32'h5C220000, 32'h9D58DC9F);
        idle(1);

        // Reset asserted in S3 with valid high.
        vcyc(1'b1, 32'h000013DB, 32'h45530000);
        vcyc(1'b1, 32'h000013DB, 32'h45530000);
        vcyc(1'b1, 32'h000013DB, 32'h45530000);
        step(1'b1, 1'b1, 32'h000013DB, 32'h45530000, 1'b0, '0, 1'b1, 1'b1, 32'hBCA14D8E);
        idle(2);

        r1 = $urandom;
        r2 = $urandom;
        e  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r1 = $urandom;
                r2 = $urandom;
                e  = 1'($urandom_range(0, 1));
            end
            rnd = $urandom_range(0, 99);
            step(rnd < 88, e, r1, r2, rnd >= 95 && rnd < 98, $urandom, rnd >= 98, 1'b0, '0);
        end
        idle(3);

        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL pending got=%0d exp=0", sbq.size());
        end
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
